pm_fetch_ctrl: RTL and testbench

Fetch controller for the slow program ROM in the 4-bit microprocessor. It takes fetch requests from program_sequencer, drives the ROM address and read strobe, and waits a fixed number of ROM wait states. It then captures the instruction byte for instruction_decoder and holds core_stall high so the sequencer, decoder and computational unit stay frozen until the byte is valid. It also handles jump flushes, an overrun error flag and a stall-cycle statistic.

---
 rtl/pm_fetch_pkg.sv | 22 ++
 rtl/pm_fetch_ctrl_wait_counter.sv | 38 +++
 rtl/pm_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_pm_fetch_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pm_fetch_pkg.sv
// Shared types and constants for the program-memory fetch controller.
package pm_fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int WAIT_W     = 4;
  localparam logic [7:0] RESET_VECTOR = 8'h00;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) r = 8'hFF;
    else            r = v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/pm_fetch_ctrl_wait_counter.sv
// Loadable down-counter that times the ROM wait states; parks at zero.
module wait_counter
  import pm_fetch_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: load wins over decrement, decrement stops at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pm_fetch_ctrl.sv
// Program ROM fetch controller: issues ROM reads, waits out the ROM latency,
// captures the instruction byte and stalls the core meanwhile.
module pm_fetch_ctrl
  import pm_fetch_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] seq_addr,
  input  logic              seq_addr_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              core_stall,
  output logic              overrun,
  output logic [7:0]        stall_cycles
);

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
  logic [DATA_W-1:0] instr_d, instr_q;
  logic              valid_d, valid_q;
  logic              overrun_d, overrun_q;
  logic [7:0]        stall_d, stall_q;

  logic boot_fetch_s;
  logic accept_s;
  logic capture_s;
  logic ovr_evt_s;
  logic cnt_zero_s;
  logic core_stall_s;
  logic rom_rd_s;

  wait_counter #(.W(WAIT_W)) u_wait_counter (
    .clk      (clk),
    .rst_n    (reset),
    .load     (boot_fetch_s | accept_s),
    .load_val (WAIT_W'(WAIT_STATES)),
    .en       (state_q == WAIT),
    .zero     (cnt_zero_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // FSM next state and fetch events; flush beats both capture and overrun
  always_comb begin
    state_d      = state_q;
    boot_fetch_s = 1'b0;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    ovr_evt_s    = 1'b0;
    case (state_q)
      BOOT: begin
        state_d      = WAIT;
        boot_fetch_s = 1'b1;
        ovr_evt_s    = seq_addr_valid & ~flush;
      end
      IDLE: begin
        if (seq_addr_valid) begin
          state_d  = WAIT;
          accept_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          if (seq_addr_valid) begin
            state_d  = WAIT;
            accept_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ovr_evt_s = seq_addr_valid;
          if (cnt_zero_s) begin
            state_d   = IDLE;
            capture_s = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // FSM output decode
  always_comb begin
    core_stall_s = 1'b1;
    rom_rd_s     = 1'b0;
    case (state_q)
      BOOT:    begin core_stall_s = 1'b1; rom_rd_s = 1'b0; end
      IDLE:    begin core_stall_s = 1'b0; rom_rd_s = 1'b0; end
      WAIT:    begin core_stall_s = 1'b1; rom_rd_s = 1'b1; end
      default: begin core_stall_s = 1'b1; rom_rd_s = 1'b0; end
    endcase
  end

  // Datapath next values: address latch, capture, sticky overrun, statistic
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (boot_fetch_s) begin
      rom_addr_d = ADDR_W'(RESET_VECTOR);
    end else if (accept_s) begin
      rom_addr_d = seq_addr;
    end else begin
      rom_addr_d = rom_addr_q;
    end

    if (capture_s) instr_d = rom_data;
    else           instr_d = instr_q;

    valid_d   = capture_s;
    overrun_d = overrun_q | ovr_evt_s;

    if (core_stall_s) stall_d = sat_inc8(stall_q);
    else              stall_d = stall_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      stall_q    <= 8'h00;
    end else begin
      rom_addr_q <= rom_addr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      stall_q    <= stall_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign rom_rd       = rom_rd_s;
  assign instr        = instr_q;
  // A flush while the pulse is out means the decoder must not consume it
  assign instr_valid  = valid_q & ~flush;
  assign core_stall   = core_stall_s;
  assign overrun      = overrun_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pm_fetch_ctrl.sv
// Randomised bench for pm_fetch_ctrl: transaction-level reference model with a
// scoreboard of expected instruction bytes drained by an independent monitor.
module tb_pm_fetch_ctrl;

  localparam int WS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] seq_addr = 8'h00;
  logic       seq_addr_valid = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] rom_data;
  logic [7:0] rom_addr;
  logic       rom_rd;
  logic [7:0] instr;
  logic       instr_valid;
  logic       core_stall;
  logic       overrun;
  logic [7:0] stall_cycles;

  always #5 clk = ~clk;

  // ROM model: each location holds its address XOR 0xA5
  assign rom_data = rom_rd ? (rom_addr ^ 8'hA5) : 8'h00;

  pm_fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(WS)) dut (
    .clk            (clk),
    .reset          (reset),
    .seq_addr       (seq_addr),
    .seq_addr_valid (seq_addr_valid),
    .flush          (flush),
    .rom_data       (rom_data),
    .rom_addr       (rom_addr),
    .rom_rd         (rom_rd),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .core_stall     (core_stall),
    .overrun        (overrun),
    .stall_cycles   (stall_cycles)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // Reference model: a fetch is "pending" until its completion cycle number
  bit         m_boot, m_pend, m_valid, m_ovr;
  logic [7:0] m_addr, m_instr;
  int         m_stall, m_end, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_boot = 1'b0; m_pend = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    m_addr = 8'h00; m_instr = 8'h00; m_stall = 0; m_end = 0; cyc = 0;
    exp_q.delete();
  endtask

  task automatic start_fetch(input logic [7:0] a);
    m_pend = 1'b1;
    m_addr = a;
    m_end  = cyc + 1 + WS;
  endtask

  // Called at posedge+1; leaves at the next posedge+1
  task automatic step(input bit v, input logic [7:0] a, input bit f);
    bit stall_now;
    seq_addr_valid = v; seq_addr = a; flush = f;
    if (m_valid && f && exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    stall_now = m_boot || m_pend;
    chk("core_stall", core_stall, stall_now);
    chk("rom_rd", rom_rd, m_pend);
    chk("rom_addr", rom_addr, m_addr);
    chk("instr", instr, m_instr);
    chk("instr_valid", instr_valid, m_valid && !f);
    chk("overrun", overrun, m_ovr);
    chk("stall_cycles", stall_cycles, m_stall);

    if (stall_now && m_stall < 255) m_stall++;
    m_valid = 1'b0;
    if (m_boot) begin
      if (v && !f) m_ovr = 1'b1;
      m_boot = 1'b0;
      start_fetch(8'h00);
    end else if (m_pend) begin
      if (f) begin
        m_pend = 1'b0;
        if (v) start_fetch(a);
      end else begin
        if (v) m_ovr = 1'b1;
        if (cyc == m_end) begin
          m_pend  = 1'b0;
          m_instr = m_addr ^ 8'hA5;
          m_valid = 1'b1;
          exp_q.push_back(m_instr);
        end
      end
    end else if (v) begin
      start_fetch(a);
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  // Asserts reset asynchronously, checks reset values, releases into BOOT
  task automatic do_reset();
    reset = 1'b0; seq_addr_valid = 1'b0; flush = 1'b0; seq_addr = 8'h00;
    #1;
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("rst_rom_rd", rom_rd, 1'b0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_core_stall", core_stall, 1'b1);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_stall_cycles", stall_cycles, 8'h00);
    model_clear();
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    m_boot = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: every instr_valid pulse must match the oldest expected byte
  always @(negedge clk) begin
    if (reset && instr_valid) begin
      chk("scoreboard_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("instr_data", instr, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    do_reset();
    idle(6);                                          // boot fetch of 0x00

    step(1'b1, 8'h3C, 1'b0); idle(5);                 // plain fetch

    step(1'b1, 8'h10, 1'b0); idle(1);                 // flush on 2nd WAIT cycle
    step(1'b0, 8'h00, 1'b1); idle(1);
    step(1'b1, 8'h20, 1'b0); idle(5);

    step(1'b1, 8'h10, 1'b0); idle(1);                 // flush with new request
    step(1'b1, 8'h7F, 1'b1); idle(5);

    step(1'b1, 8'h44, 1'b0);                          // overrun during WAIT
    step(1'b1, 8'h55, 1'b0); idle(5);

    step(1'b1, 8'h66, 1'b0); idle(WS);                // capture edge flush
    step(1'b0, 8'h00, 1'b1); idle(3);

    step(1'b1, 8'h09, 1'b0); idle(WS + 1);            // flush during valid pulse
    step(1'b0, 8'h00, 1'b1); idle(3);

    step(1'b1, 8'h31, 1'b0); idle(1);                 // reset mid-WAIT
    do_reset();
    idle(6);

    for (int i = 0; i < 400; i++) step(1'b1, 8'($urandom), 1'b0);  // saturate stall count

    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 9) == 0));

    idle(WS + 6);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
